// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Widths mirror the core configuration; tWbSrc encodes grant and round-robin pointer.
package wb_port_arbiter_pkg;

    localparam int cXLEN       = 32;
    localparam int cRegSelBitW = 5;
    localparam int cRegNum     = 32;

    typedef struct packed {
        logic                   dv;
        logic [cRegSelBitW-1:0] addr;
    } tRegOp;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } tWbSrc;

    function automatic logic [cRegNum-1:0] reg_onehot(
        input logic                   valid,
        input logic [cRegSelBitW-1:0] addr
    );
        logic [cRegNum-1:0] v_bit;
        v_bit = '0;
        if (valid) begin
            v_bit[addr] = 1'b1;
        end
        return v_bit;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundles both writeback requesters and the regFile write port.
// Handshake: a request is taken on a rising edge where dv && ready; the requester holds dv/addr/data stable until then.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    tRegOp              iAluRd;
    logic [cXLEN-1:0]   iAluData;
    logic               oAluReady;
    tRegOp              iMemRd;
    logic [cXLEN-1:0]   iMemData;
    logic               oMemReady;
    tRegOp              oRd;
    logic [cXLEN-1:0]   oRdData;
    logic [cRegNum-1:0] oPending;
    tWbSrc              dbgLastGrant;

    modport slave (
        input  iAluRd, iAluData, iMemRd, iMemData,
        output oAluReady, oMemReady, oRd, oRdData, oPending, dbgLastGrant
    );

    modport master (
        output iAluRd, iAluData, iMemRd, iMemData,
        input  oAluReady, oMemReady, oRd, oRdData, oPending, dbgLastGrant
    );

endinterface

// File: rtl/wb_hold_buf.sv
// One-entry writeback holding buffer with ready generation, x0 filtering and age tracking.
// Next-state valid/addr are exported so the owner can register the pending bitmap in step.
module wb_hold_buf
    import wb_port_arbiter_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  tRegOp                  i_req,
    input  logic [cXLEN-1:0]       i_data,
    input  logic                   i_grant,
    input  logic                   i_any_grant,
    input  logic                   i_other_capture,
    output logic                   o_ready,
    output logic                   o_capture,
    output logic                   o_valid,
    output logic [cRegSelBitW-1:0] o_addr,
    output logic [cXLEN-1:0]       o_data,
    output logic                   o_age,
    output logic                   o_valid_nxt,
    output logic [cRegSelBitW-1:0] o_addr_nxt
);

    logic                   r_valid;
    logic [cRegSelBitW-1:0] r_addr;
    logic [cXLEN-1:0]       r_data;
    logic                   r_age;

    logic w_accept;
    logic w_capture;
    logic w_stays;

    assign o_ready   = !r_valid || i_grant;
    assign w_accept  = i_req.dv && o_ready;
    // Writes to x0 are swallowed here so they never occupy the slot or reach the port.
    assign w_capture = w_accept && (i_req.addr != '0);
    assign w_stays   = r_valid && !i_grant;

    assign o_valid_nxt = w_capture || w_stays;
    assign o_addr_nxt  = w_capture ? i_req.addr : r_addr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_age   <= 1'b0;
        end else begin
            r_valid <= o_valid_nxt;
            if (w_capture) begin
                r_addr <= i_req.addr;
                r_data <= i_data;
            end
            // A surviving entry becomes older than anything the other side takes this edge.
            if (w_stays && i_other_capture) begin
                r_age <= 1'b1;
            end else if (i_any_grant) begin
                r_age <= 1'b0;
            end
        end
    end

    assign o_capture = w_capture;
    assign o_valid   = r_valid;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_age     = r_age;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regFile write port between the ALU and load writeback buffers.
// Round-robin between distinct destinations, oldest-first for a shared destination.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
(
    input  logic              iClk,
    input  logic              iRst,
    wb_port_arbiter_if.slave  bus
);

    logic                   w_alu_ready, w_alu_capture, w_alu_valid, w_alu_age, w_alu_valid_nxt;
    logic [cRegSelBitW-1:0] w_alu_addr, w_alu_addr_nxt;
    logic [cXLEN-1:0]       w_alu_data;
    logic                   w_mem_ready, w_mem_capture, w_mem_valid, w_mem_age, w_mem_valid_nxt;
    logic [cRegSelBitW-1:0] w_mem_addr, w_mem_addr_nxt;
    logic [cXLEN-1:0]       w_mem_data;

    logic w_grant_alu;
    logic w_grant_mem;
    logic w_grant_any;
    logic w_rr_flip;

    tWbSrc              r_last_grant;
    tRegOp              r_rd;
    logic [cXLEN-1:0]   r_rd_data;
    logic [cRegNum-1:0] r_pending;

    assign w_grant_any = w_grant_alu || w_grant_mem;

    wb_hold_buf u_alu_buf (
        .i_clk           (iClk),
        .i_rst_n         (iRst),
        .i_req           (bus.iAluRd),
        .i_data          (bus.iAluData),
        .i_grant         (w_grant_alu),
        .i_any_grant     (w_grant_any),
        .i_other_capture (w_mem_capture),
        .o_ready         (w_alu_ready),
        .o_capture       (w_alu_capture),
        .o_valid         (w_alu_valid),
        .o_addr          (w_alu_addr),
        .o_data          (w_alu_data),
        .o_age           (w_alu_age),
        .o_valid_nxt     (w_alu_valid_nxt),
        .o_addr_nxt      (w_alu_addr_nxt)
    );

    wb_hold_buf u_mem_buf (
        .i_clk           (iClk),
        .i_rst_n         (iRst),
        .i_req           (bus.iMemRd),
        .i_data          (bus.iMemData),
        .i_grant         (w_grant_mem),
        .i_any_grant     (w_grant_any),
        .i_other_capture (w_alu_capture),
        .o_ready         (w_mem_ready),
        .o_capture       (w_mem_capture),
        .o_valid         (w_mem_valid),
        .o_addr          (w_mem_addr),
        .o_data          (w_mem_data),
        .o_age           (w_mem_age),
        .o_valid_nxt     (w_mem_valid_nxt),
        .o_addr_nxt      (w_mem_addr_nxt)
    );

    // Same destination: the load only wins when it alone carries the age mark,
    // so a simultaneous capture resolves to the ALU entry.
    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_mem = 1'b0;
        w_rr_flip   = 1'b0;
        if (w_alu_valid && w_mem_valid) begin
            if (w_alu_addr == w_mem_addr) begin
                if (w_mem_age && !w_alu_age) begin
                    w_grant_mem = 1'b1;
                end else begin
                    w_grant_alu = 1'b1;
                end
            end else begin
                w_rr_flip = 1'b1;
                if (r_last_grant == WB_ALU) begin
                    w_grant_mem = 1'b1;
                end else begin
                    w_grant_alu = 1'b1;
                end
            end
        end else if (w_alu_valid) begin
            w_grant_alu = 1'b1;
        end else if (w_mem_valid) begin
            w_grant_mem = 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_last_grant <= WB_MEM;
            r_rd         <= '0;
            r_rd_data    <= '0;
            r_pending    <= '0;
        end else begin
            if (w_rr_flip) begin
                r_last_grant <= w_grant_mem ? WB_MEM : WB_ALU;
            end
            r_rd.dv <= w_grant_any;
            if (w_grant_alu) begin
                r_rd.addr <= w_alu_addr;
                r_rd_data <= w_alu_data;
            end else if (w_grant_mem) begin
                r_rd.addr <= w_mem_addr;
                r_rd_data <= w_mem_data;
            end
            r_pending <= reg_onehot(w_alu_valid_nxt, w_alu_addr_nxt)
                       | reg_onehot(w_mem_valid_nxt, w_mem_addr_nxt);
        end
    end

    assign bus.oAluReady    = w_alu_ready;
    assign bus.oMemReady    = w_mem_ready;
    assign bus.oRd          = r_rd;
    assign bus.oRdData      = r_rd_data;
    assign bus.oPending     = r_pending;
    assign bus.dbgLastGrant = r_last_grant;

endmodule
